// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_sequencer
// Purpose  : Walks a 4:1 mux select through the enabled channels, captures the
//            mux output after a settle time, and flags each completed frame.
// Option   : MUX_SCAN_CHANGE_EN adds the 'changed' output.
// Revision : 1.0
// ============================================================================
module mux_scan_sequencer #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic [3:0] ch_en,
  input  logic       mux_y,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] samples,
  output logic       frame_valid
`ifdef MUX_SCAN_CHANGE_EN
  ,
  output logic       changed
`endif
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SETTLE - 1);

  logic [0:0]       state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [3:0]       samples_q, samples_d;
  logic             fv_q, fv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ch_en_q, ch_en_d;

  logic             w_has_next;
  logic [1:0]       w_next_sel;

`ifdef MUX_SCAN_CHANGE_EN
  logic [3:0]       ref_q, ref_d;
  logic             chg_q, chg_d;
`endif

  function automatic logic [1:0] lowest_set(input logic [3:0] mask);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) lowest_set = 2'(i);
    end
  endfunction

  // Descending scan so the last hit is the nearest enabled channel above sel.
  always_comb begin
    w_has_next = 1'b0;
    w_next_sel = sel_q;
    for (int i = 3; i >= 0; i--) begin
      if (ch_en_q[i] && (i > int'(sel_q))) begin
        w_has_next = 1'b1;
        w_next_sel = 2'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    samples_d = samples_q;
    fv_d      = 1'b0;
    cnt_d     = cnt_q;
    ch_en_d   = ch_en_q;
`ifdef MUX_SCAN_CHANGE_EN
    ref_d     = ref_q;
    chg_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && (ch_en != 4'd0)) begin
          state_d = ST_SETTLE;
          ch_en_d = ch_en;
          sel_d   = lowest_set(ch_en);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == c_cnt_last) begin
          cnt_d            = '0;
          samples_d[sel_q] = mux_y;
          if (w_has_next) begin
            sel_d = w_next_sel;
          end else begin
            fv_d = 1'b1;
`ifdef MUX_SCAN_CHANGE_EN
            chg_d = (samples_d != ref_q);
            ref_d = samples_d;
`endif
            if (continuous && (ch_en != 4'd0)) begin
              ch_en_d = ch_en;
              sel_d   = lowest_set(ch_en);
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      samples_q <= 4'd0;
      fv_q      <= 1'b0;
      cnt_q     <= '0;
      ch_en_q   <= 4'd0;
`ifdef MUX_SCAN_CHANGE_EN
      ref_q     <= 4'd0;
      chg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      samples_q <= samples_d;
      fv_q      <= fv_d;
      cnt_q     <= cnt_d;
      ch_en_q   <= ch_en_d;
`ifdef MUX_SCAN_CHANGE_EN
      ref_q     <= ref_d;
      chg_q     <= chg_d;
`endif
    end
  end

  assign sel         = sel_q;
  assign busy        = busy_q;
  assign samples     = samples_q;
  assign frame_valid = fv_q;
`ifdef MUX_SCAN_CHANGE_EN
  assign changed     = chg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_sequencer
// Purpose  : Directed self-checking bench for mux_scan_sequencer (SETTLE=2).
// Revision : 1.0
// ============================================================================
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] ch_en = 4'd0;
  logic       mux_y;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] samples;
  logic       frame_valid;
`ifdef MUX_SCAN_CHANGE_EN
  logic       changed;
`endif

  // External 4:1 mux: bit i of mux_vec is the level on input i.
  logic [3:0] mux_vec = 4'b1101;
  assign mux_y = mux_vec[sel];

  int total = 0;
  int bad   = 0;

  mux_scan_sequencer #(.SETTLE(2), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .continuous  (continuous),
    .ch_en       (ch_en),
    .mux_y       (mux_y),
    .sel         (sel),
    .busy        (busy),
    .samples     (samples),
    .frame_valid (frame_valid)
`ifdef MUX_SCAN_CHANGE_EN
    ,
    .changed     (changed)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (samples !== 4'd0) begin bad++; $display("FAIL reset_samples got=%b exp=0000", samples); end
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%0b exp=0", frame_valid); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_scan();
    logic [1:0] exp_sel;
    ch_en   = 4'b1111;
    mux_vec = 4'b1101;
    start   = 1'b1;
    step();
    start   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_sel = 2'(k / 2);
      total++; if (sel !== exp_sel) begin bad++; $display("FAIL scan_sel k=%0d got=%0d exp=%0d", k, sel, exp_sel); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy k=%0d got=%0b exp=1", k, busy); end
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL scan_fv_early k=%0d got=%0b exp=0", k, frame_valid); end
      step();
    end
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL scan_fv got=%0b exp=1", frame_valid); end
    total++; if (samples !== 4'b1101) begin bad++; $display("FAIL scan_samples got=%b exp=1101", samples); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL scan_busy_end got=%0b exp=0", busy); end
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL scan_fv_pulse got=%0b exp=0", frame_valid); end
  endtask

  task automatic test_sparse_mask();
    // Preset samples to 0101 by scanning every channel against that pattern.
    ch_en   = 4'b1111;
    mux_vec = 4'b0101;
    start   = 1'b1;
    step();
    start   = 1'b0;
    repeat (8) step();
    total++; if (samples !== 4'b0101) begin bad++; $display("FAIL sparse_preset got=%b exp=0101", samples); end
    step();
    mux_vec = 4'b1101;
    ch_en   = 4'b1010;
    start   = 1'b1;
    step();
    start   = 1'b0;
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL sparse_sel0 got=%0d exp=1", sel); end
    step();
    step();
    total++; if (sel !== 2'd3) begin bad++; $display("FAIL sparse_sel1 got=%0d exp=3", sel); end
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL sparse_fv_early got=%0b exp=0", frame_valid); end
    step();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL sparse_fv got=%0b exp=1", frame_valid); end
    // b=0 and d=1 captured; bits 0 and 2 keep their preset 1s.
    total++; if (samples !== 4'b1101) begin bad++; $display("FAIL sparse_samples got=%b exp=1101", samples); end
    step();
  endtask

  task automatic test_continuous();
    ch_en      = 4'b0001;
    mux_vec    = 4'b1101;
    continuous = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL cont_fv1_early got=%0b exp=0", frame_valid); end
    step();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL cont_fv1 got=%0b exp=1", frame_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_busy1 got=%0b exp=1", busy); end
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL cont_gap got=%0b exp=0", frame_valid); end
    step();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL cont_fv2 got=%0b exp=1", frame_valid); end
    continuous = 1'b0;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL cont_last_busy got=%0b exp=1", busy); end
    step();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL cont_fv3 got=%0b exp=1", frame_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_stop_busy got=%0b exp=0", busy); end
    step();
    total++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL cont_idle got=%0b%0b exp=00", frame_valid, busy); end
  endtask

  task automatic test_ignored_start();
    ch_en = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_start_busy got=%0b exp=0", busy); end
    ch_en = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    // Busy restart attempt plus a mask change, neither may alter the frame.
    start = 1'b1;
    ch_en = 4'b0001;
    step();
    start = 1'b0;
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL busy_start_sel got=%0d exp=2", sel); end
    step();
    step();
    total++; if (sel !== 2'd3) begin bad++; $display("FAIL busy_start_sel3 got=%0d exp=3", sel); end
    step();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL busy_start_fv_early got=%0b exp=0", frame_valid); end
    step();
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL busy_start_fv got=%0b exp=1", frame_valid); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_mid_reset();
    int fv_seen;
    ch_en   = 4'b1111;
    mux_vec = 4'b1101;
    start   = 1'b1;
    step();
    start   = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL midrst_sel got=%0d exp=0", sel); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    total++; if (samples !== 4'd0) begin bad++; $display("FAIL midrst_samples got=%b exp=0000", samples); end
    fv_seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (frame_valid !== 1'b0) fv_seen++;
      step();
    end
    total++; if (fv_seen != 0) begin bad++; $display("FAIL midrst_fv got=%0d exp=0", fv_seen); end
  endtask

`ifdef MUX_SCAN_CHANGE_EN
  task automatic test_changed();
    logic [3:0] pat [3];
    logic       exp_chg [3];
    pat[0] = 4'b1101; exp_chg[0] = 1'b1;
    pat[1] = 4'b1101; exp_chg[1] = 1'b0;
    pat[2] = 4'b1111; exp_chg[2] = 1'b1;
    ch_en = 4'b1111;
    for (int f = 0; f < 3; f++) begin
      mux_vec = pat[f];
      start   = 1'b1;
      step();
      start   = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (changed !== 1'b0) begin total++; bad++; $display("FAIL chg_idle f=%0d got=%0b exp=0", f, changed); end
        step();
      end
      total++; if (changed !== 1'b0) begin bad++; $display("FAIL chg_pre f=%0d got=%0b exp=0", f, changed); end
      step();
      total++; if (changed !== exp_chg[f]) begin bad++; $display("FAIL chg_frame f=%0d got=%0b exp=%0b", f, changed, exp_chg[f]); end
      step();
      total++; if (changed !== 1'b0) begin bad++; $display("FAIL chg_pulse f=%0d got=%0b exp=0", f, changed); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_scan();
    test_sparse_mask();
    test_continuous();
    test_ignored_start();
    test_mid_reset();
`ifdef MUX_SCAN_CHANGE_EN
    test_changed();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
